// File: rtl/col_norm_sqrt_engine.sv
// col_norm_sqrt_engine: Euclidean norm of a complex column, sum of squares then iterative restoring sqrt.
module col_norm_sqrt_engine #(
  parameter int N_RX     = 4,
  parameter int W        = 24,
  parameter int FRAC     = 22,
  parameter int OUT_W    = 20,
  parameter int OUT_FRAC = 16,
  parameter int P        = 2,
  parameter int TAG_W    = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2*W*N_RX-1:0]   i_col,
  input  logic [TAG_W-1:0]      i_tag,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [OUT_W-1:0]      o_rii,
  output logic                  o_zero,
  output logic                  o_sat,
  output logic [TAG_W-1:0]      o_tag
);
  localparam int SQ_RAW = 2*W + $clog2(N_RX) + 1;
  localparam int SQ_W   = ((SQ_RAW + 2*P - 1) / (2*P)) * (2*P);
  localparam int R_W    = SQ_W / 2;
  localparam int ITER   = R_W / P;
  localparam int CW     = $clog2(ITER + 1);
  localparam int SH     = FRAC - OUT_FRAC;
  localparam int RB     = (SH > 0) ? SH - 1 : 0;

  typedef enum logic [1:0] {IDLE, SUM, SQRT, DONE} state_t;

  state_t               state_q;
  logic [2*W*N_RX-1:0]  col_q;
  logic [TAG_W-1:0]     tag_q;
  logic [SQ_W-1:0]      rad_q;
  logic [R_W+1:0]       rem_q;
  logic [R_W-1:0]       root_q;
  logic [CW-1:0]        cnt_q;
  logic                 valid_q, zero_q, sat_q;
  logic [OUT_W-1:0]     rii_q;
  logic [TAG_W-1:0]     otag_q;

  logic signed [W-1:0]  re, im;
  logic signed [2*W:0]  pw;
  logic [SQ_W-1:0]      sum_d, rad_d;
  logic [R_W+1:0]       rem_d, trial;
  logic [R_W-1:0]       root_d;
  logic                 ge;
  logic [R_W:0]         r_full;
  logic                 sat_d;
  logic [OUT_W-1:0]     rii_d;

  always_comb begin
    sum_d = '0;
    re    = '0;
    im    = '0;
    pw    = '0;
    for (int k = 0; k < N_RX; k++) begin
      re    = col_q[2*W*k +: W];
      im    = col_q[2*W*k+W +: W];
      pw    = re*re + im*im;
      sum_d = sum_d + SQ_W'(pw);
    end
  end

  // P restoring steps per cycle: bring down two radicand bits, try subtracting 4*root+1
  always_comb begin
    rem_d  = rem_q;
    root_d = root_q;
    rad_d  = rad_q;
    trial  = '0;
    ge     = 1'b0;
    for (int j = 0; j < P; j++) begin
      rem_d  = {rem_d[R_W-1:0], rad_d[SQ_W-1 -: 2]};
      trial  = {root_d, 2'b01};
      ge     = rem_d >= trial;
      rem_d  = ge ? rem_d - trial : rem_d;
      root_d = {root_d[R_W-2:0], ge};
      rad_d  = rad_d << 2;
    end
  end

  assign r_full = {1'b0, root_q >> SH} + {{R_W{1'b0}}, (SH > 0) ? root_q[RB] : 1'b0};
  assign sat_d  = |(r_full >> OUT_W);
  assign rii_d  = sat_d ? '1 : OUT_W'(r_full);

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      tag_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      sat_q   <= 1'b0;
      rii_q   <= '0;
      otag_q  <= '0;
    end else if (i_flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          col_q   <= i_col;
          tag_q   <= i_tag;
          state_q <= SUM;
        end
        SUM: begin
          rad_q   <= sum_d;
          rem_q   <= '0;
          root_q  <= '0;
          cnt_q   <= '0;
          state_q <= SQRT;
        end
        SQRT: if (cnt_q == CW'(ITER)) begin
          rii_q   <= rii_d;
          sat_q   <= sat_d;
          zero_q  <= root_q == '0;
          otag_q  <= tag_q;
          valid_q <= 1'b1;
          state_q <= DONE;
        end else begin
          rem_q   <= rem_d;
          root_q  <= root_d;
          rad_q   <= rad_d;
          cnt_q   <= cnt_q + CW'(1);
        end
        default: if (i_ready) begin
          valid_q <= 1'b0;
          if (i_valid) begin
            col_q   <= i_col;
            tag_q   <= i_tag;
            state_q <= SUM;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end

  assign o_ready = (state_q == IDLE) || (state_q == DONE && i_ready);
  assign o_valid = valid_q;
  assign o_rii   = rii_q;
  assign o_zero  = zero_q;
  assign o_sat   = sat_q;
  assign o_tag   = otag_q;
endmodule

// File: tb/tb_col_norm_sqrt_engine.sv
// tb_col_norm_sqrt_engine: three configurations (default, OUT_W=18, P=1) checked against an arithmetic norm model.
module tb_col_norm_sqrt_engine;
  localparam int N = 4, W = 24, TW = 5, CWID = 2*W*N, SH = 6;

  logic clk = 0, rst_n = 0, flush = 0;
  logic [CWID-1:0] col = '0;
  logic [TW-1:0] tag = '0;
  logic vin[3], rdy_in[3];
  logic ordy[3], ov[3], zo[3], so[3];
  logic [TW-1:0] otag[3];
  logic [19:0] rii0, rii2;
  logic [17:0] rii1;
  logic [19:0] rii_a[3];
  int checks = 0, fails = 0;
  longint ecnt = 0;
  int lat[3] = '{15, 15, 28};
  int owc[3] = '{20, 18, 20};
  bit live[3], ovp[3], rexp[3], ez[3], es[3];
  longint acc[3], er[3];
  logic [TW-1:0] et[3];

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  assign rii_a[0] = rii0;
  assign rii_a[1] = {2'b00, rii1};
  assign rii_a[2] = rii2;

  col_norm_sqrt_engine u0 (.i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(vin[0]), .o_ready(ordy[0]),
    .i_col(col), .i_tag(tag), .o_valid(ov[0]), .i_ready(rdy_in[0]), .o_rii(rii0), .o_zero(zo[0]), .o_sat(so[0]), .o_tag(otag[0]));
  col_norm_sqrt_engine #(.OUT_W(18)) u1 (.i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(vin[1]), .o_ready(ordy[1]),
    .i_col(col), .i_tag(tag), .o_valid(ov[1]), .i_ready(rdy_in[1]), .o_rii(rii1), .o_zero(zo[1]), .o_sat(so[1]), .o_tag(otag[1]));
  col_norm_sqrt_engine #(.P(1)) u2 (.i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(vin[2]), .o_ready(ordy[2]),
    .i_col(col), .i_tag(tag), .o_valid(ov[2]), .i_ready(rdy_in[2]), .o_rii(rii2), .o_zero(zo[2]), .o_sat(so[2]), .o_tag(otag[2]));

  task automatic chk(input string nm, input int i, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, i, a, e);
    end
  endtask

  // Exact integer floor-sqrt of the energy, then round-half-up to OUT_FRAC bits and clamp
  function automatic void model(input logic [CWID-1:0] c, input int ow, output longint r, output bit z, output bit s);
    longint sum = 0, re, im, rt, q;
    for (int k = 0; k < N; k++) begin
      re = longint'($signed(c[2*W*k +: W]));
      im = longint'($signed(c[2*W*k+W +: W]));
      sum += re*re + im*im;
    end
    rt = longint'($sqrt(real'(sum)));
    while (rt*rt > sum) rt--;
    while ((rt+1)*(rt+1) <= sum) rt++;
    q = (rt + (longint'(1) << (SH-1))) >> SH;
    s = q >= (longint'(1) << ow);
    r = s ? (longint'(1) << ow) - 1 : q;
    z = sum == 0;
  endfunction

  function automatic logic [CWID-1:0] mk(input logic [W-1:0] re, input logic [W-1:0] im, input int rows);
    mk = '0;
    for (int k = 0; k < rows; k++) begin
      mk[2*W*k +: W]   = re;
      mk[2*W*k+W +: W] = im;
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        chk("rst_valid", i, ov[i], 0);
        chk("rst_rii", i, rii_a[i], 0);
        chk("rst_zero", i, zo[i], 0);
        chk("rst_sat", i, so[i], 0);
        chk("rst_tag", i, otag[i], 0);
        live[i] = 0;
      end else begin
        rexp[i] = !live[i] || ((ecnt - acc[i]) >= longint'(lat[i]) && rdy_in[i]);
        chk("ready", i, ordy[i], rexp[i]);
        if (ov[i]) begin
          if (!live[i]) chk("valid_unexpected", i, ov[i], live[i]);
          else begin
            if (!ovp[i]) chk("latency", i, ecnt - acc[i], lat[i]);
            chk("rii", i, rii_a[i], er[i]);
            chk("zero", i, zo[i], ez[i]);
            chk("sat", i, so[i], es[i]);
            chk("tag", i, otag[i], et[i]);
          end
        end else if (live[i] && (ecnt - acc[i]) >= longint'(lat[i])) begin
          chk("valid_missing", i, ov[i], 1);
          live[i] = 0;
        end
        if (flush) live[i] = 0;
        else begin
          if (ov[i] && rdy_in[i]) live[i] = 0;
          if (vin[i] && rexp[i]) begin
            live[i] = 1;
            acc[i] = ecnt + 1;
            model(col, owc[i], er[i], ez[i], es[i]);
            et[i] = tag;
          end
        end
      end
      ovp[i] = ov[i];
    end
  end

  task automatic send(input int i, input logic [CWID-1:0] c, input logic [TW-1:0] t);
    int n = 0;
    bit ok = 0;
    col = c;
    tag = t;
    vin[i] = 1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = ordy[i] && !flush;
      @(posedge clk);
      #1;
      n++;
    end
    vin[i] = 0;
    if (!ok) chk("send_accept", i, ok, 1);
  endtask

  task automatic wait_out(input int i, output bit got);
    int n = 0;
    got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = ov[i];
      n++;
    end
    if (!got) chk("result_timeout", i, got, 1);
  endtask

  task automatic run(input int i, input logic [CWID-1:0] c, input logic [TW-1:0] t,
                     input logic [19:0] xr, input bit xz, input bit xs, input string nm);
    bit got;
    send(i, c, t);
    wait_out(i, got);
    if (got) begin
      chk({nm, "_rii"}, i, rii_a[i], xr);
      chk({nm, "_zero"}, i, zo[i], xz);
      chk({nm, "_sat"}, i, so[i], xs);
      chk({nm, "_tag"}, i, otag[i], t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stall_b2b(input int i);
    bit got;
    rdy_in[i] = 0;
    send(i, mk(24'h0C0000, 24'h100000, 4), 10);
    wait_out(i, got);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("hold_rii", i, rii_a[i], 20'h0A000);
      chk("hold_valid", i, ov[i], 1);
      chk("hold_ready", i, ordy[i], 0);
    end
    @(posedge clk);
    #1;
    rdy_in[i] = 1;
    send(i, mk(24'h400000, 24'h0, 2), 11);
    wait_out(i, got);
    if (got) begin
      chk("b2b_rii", i, rii_a[i], 20'h16A0A);
      chk("b2b_tag", i, otag[i], 11);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string nm, output bit seen);
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      seen |= ov[0];
    end
    chk(nm, 0, seen, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    vin = '{0, 0, 0};
    rdy_in = '{1, 1, 1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", 0, ordy[0], 1);
    @(posedge clk);
    #1;
    run(0, mk(24'h400000, 24'h0, 4), 1, 20'h20000, 0, 0, "unit_rows");
    run(0, mk(24'h0C0000, 24'h100000, 1), 2, 20'h05000, 0, 0, "row0_pos");
    run(0, mk(24'hF40000, 24'h100000, 1), 3, 20'h05000, 0, 0, "row0_neg");
    run(0, mk(24'h0, 24'h0, 4), 4, 20'h0, 1, 0, "all_zero");
    run(0, mk(24'h1, 24'h0, 1), 5, 20'h0, 0, 0, "lsb");
    run(0, mk(24'h20, 24'h0, 1), 6, 20'h1, 0, 0, "round_up");
    run(0, mk(24'h1F, 24'h0, 1), 7, 20'h0, 0, 0, "round_down");
    run(1, mk(24'h800000, 24'h800000, 4), 8, 20'h3FFFF, 0, 1, "sat18");
    run(0, mk(24'h800000, 24'h800000, 4), 9, 20'h5A828, 0, 0, "max20");
    stall_b2b(0);
    stall_b2b(2);
    send(0, mk(24'h400000, 24'h0, 4), 12);
    repeat (6) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    quiet("flush_silent", seen);
    chk("flush_keep_rii", 0, rii0, 20'h16A0A);
    chk("flush_keep_tag", 0, otag[0], 11);
    run(0, mk(24'h0C0000, 24'h100000, 1), 13, 20'h05000, 0, 0, "after_flush");
    send(0, mk(24'h400000, 24'h0, 4), 14);
    repeat (6) @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    quiet("reset_silent", seen);
    chk("reset_rii", 0, rii0, 0);
    run(0, mk(24'h400000, 24'h0, 4), 15, 20'h20000, 0, 0, "after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails);
    $fatal(1);
  end
endmodule
